// File: rtl/frog_pkg.sv
// Shared frog playfield constants: state encoding, bounds, spawn point and step size.
// The renderer imports the same package so that border, spawn and bounds agree.
package frog_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    HIT  = 3'd2,
    WIN  = 3'd3,
    OVER = 3'd4
  } state_t;

  localparam logic [10:0] STEP  = 11'd8;
  localparam logic [10:0] X_MIN = 11'd152;
  localparam logic [10:0] X_MAX = 11'd744;
  localparam logic [10:0] Y_MIN = 11'd40;
  localparam logic [10:0] Y_MAX = 11'd472;

  localparam logic [9:0] DEF_X = 10'd152;
  localparam logic [8:0] DEF_Y = 9'd240;

  localparam logic [1:0] LIVES      = 2'd3;
  localparam logic [6:0] HIT_FRAMES = 7'd60;
  localparam logic [6:0] WIN_FRAMES = 7'd30;

  // Coordinates are widened to 11 bits first, so an underflow lands far above hi.
  function automatic logic in_bounds(input logic [10:0] v,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/btn_frame_edge.sv
// Button conditioner: 2-FF synchronizer, level sampled once per frame, press = 0->1 between frames.
// press is combinational and valid only in the frame_start cycle; holding a button never repeats.
module btn_frame_edge (
  input  logic dclk,
  input  logic rst_n,
  input  logic btn,
  input  logic frame_start,
  output logic press
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
      if (frame_start) prev <= sync;
    end
  end

  assign press = frame_start & sync & ~prev;

endmodule

// File: rtl/frog_game_ctrl.sv
// Frog game sequencer: frame-aligned moves plus the IDLE/PLAY/HIT/WIN/OVER state machine.
// Everything is evaluated in the frame_start cycle and lands one dclk later, alongside coll_clr.
module frog_game_ctrl
  import frog_pkg::*;
(
  input  logic       dclk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_start,
  input  logic [3:0] collision,
  output logic       coll_clr,
  output logic [9:0] frog_x,
  output logic [8:0] frog_y,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic [3:0] level,
  output logic       flash
);

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic [1:0] lives_q, lives_d;
  logic [3:0] level_q, level_d;
  logic       flash_q, flash_d;
  logic [6:0] cnt_q, cnt_d;
  logic       fs_d, clr_q;

  logic        fs_rise;
  logic [3:0]  press;
  logic        any_press;
  logic        hit_now;
  logic [10:0] mv_x, mv_y;
  logic        mv_ok;

  // A stretched frame_start is acted on only at its first cycle.
  assign fs_rise = frame_start & ~fs_d;

  btn_frame_edge u_up    (.dclk(dclk), .rst_n(rst_n), .btn(btn_up),    .frame_start(fs_rise), .press(press[3]));
  btn_frame_edge u_down  (.dclk(dclk), .rst_n(rst_n), .btn(btn_down),  .frame_start(fs_rise), .press(press[2]));
  btn_frame_edge u_left  (.dclk(dclk), .rst_n(rst_n), .btn(btn_left),  .frame_start(fs_rise), .press(press[1]));
  btn_frame_edge u_right (.dclk(dclk), .rst_n(rst_n), .btn(btn_right), .frame_start(fs_rise), .press(press[0]));

  assign any_press = |press;
  assign hit_now   = |collision;

  // Only the highest-priority press is tried; an out-of-bounds move is dropped, not replaced.
  always_comb begin
    mv_x = {1'b0, x_q};
    mv_y = {2'b00, y_q};
    if (press[3])      mv_y = mv_y - STEP;
    else if (press[2]) mv_y = mv_y + STEP;
    else if (press[1]) mv_x = mv_x - STEP;
    else if (press[0]) mv_x = mv_x + STEP;
    mv_ok = in_bounds(mv_x, X_MIN, X_MAX) && in_bounds(mv_y, Y_MIN, Y_MAX);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    lives_d = lives_q;
    level_d = level_q;
    flash_d = flash_q;
    cnt_d   = cnt_q;
    if (fs_rise) begin
      case (state_q)
        IDLE: begin
          x_d = DEF_X;
          y_d = DEF_Y;
          if (any_press) begin
            state_d = PLAY;
            cnt_d   = 7'd0;
          end
        end
        PLAY: begin
          if (hit_now) begin
            state_d = HIT;
            cnt_d   = 7'd0;
            flash_d = 1'b0;
          end else if (any_press && mv_ok) begin
            x_d = mv_x[9:0];
            y_d = mv_y[8:0];
            if (mv_x == X_MAX) begin
              state_d = WIN;
              cnt_d   = 7'd0;
              flash_d = 1'b1;
            end
          end
        end
        HIT: begin
          cnt_d = cnt_q + 7'd1;
          if (cnt_d[2:0] == 3'd0) flash_d = ~flash_q;
          if (cnt_q == HIT_FRAMES - 7'd1) begin
            cnt_d   = 7'd0;
            flash_d = 1'b0;
            if (lives_q == 2'd1) begin
              lives_d = 2'd0;
              state_d = OVER;
            end else begin
              lives_d = lives_q - 2'd1;
              x_d     = DEF_X;
              y_d     = DEF_Y;
              state_d = PLAY;
            end
          end
        end
        WIN: begin
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == WIN_FRAMES - 7'd1) begin
            cnt_d   = 7'd0;
            flash_d = 1'b0;
            level_d = (level_q == 4'd15) ? level_q : level_q + 4'd1;
            x_d     = DEF_X;
            y_d     = DEF_Y;
            state_d = PLAY;
          end
        end
        OVER: begin
          if (any_press) begin
            state_d = IDLE;
            cnt_d   = 7'd0;
            flash_d = 1'b0;
            lives_d = LIVES;
            level_d = 4'd0;
            x_d     = DEF_X;
            y_d     = DEF_Y;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 7'd0;
        end
      endcase
    end
  end

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= DEF_X;
      y_q     <= DEF_Y;
      lives_q <= LIVES;
      level_q <= 4'd0;
      flash_q <= 1'b0;
      cnt_q   <= 7'd0;
      fs_d    <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lives_q <= lives_d;
      level_q <= level_d;
      flash_q <= flash_d;
      cnt_q   <= cnt_d;
      fs_d    <= frame_start;
      clr_q   <= fs_rise;
    end
  end

  assign coll_clr = clr_q;
  assign frog_x   = x_q;
  assign frog_y   = y_q;
  assign state    = state_q;
  assign lives    = lives_q;
  assign level    = level_q;
  assign flash    = flash_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed bench for frog_game_ctrl: one frame per task call, outputs checked one cycle after frame_start.
module tb_frog_game_ctrl;

  logic       dclk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       frame_start;
  logic [3:0] collision;
  logic       coll_clr;
  logic [9:0] frog_x;
  logic [8:0] frog_y;
  logic [2:0] state;
  logic [1:0] lives;
  logic [3:0] level;
  logic       flash;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_U    = 4'b1000;
  localparam logic [3:0] B_L    = 4'b0010;
  localparam logic [3:0] B_R    = 4'b0001;

  always #5 dclk = ~dclk;

  frog_game_ctrl dut (
    .dclk(dclk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .frame_start(frame_start), .collision(collision), .coll_clr(coll_clr),
    .frog_x(frog_x), .frog_y(frog_y), .state(state), .lives(lives),
    .level(level), .flash(flash)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // b = {up, down, left, right}; returns at a negedge one cycle after the frame_start edge.
  task automatic frame(input logic [3:0] b, input logic [3:0] c);
    {btn_up, btn_down, btn_left, btn_right} = b;
    collision = c;
    repeat (3) @(negedge dclk);
    frame_start = 1'b1;
    @(negedge dclk);
    frame_start = 1'b0;
    collision   = 4'b0000;
    chk("coll_clr_pulse", coll_clr, 1);
    @(negedge dclk);
    chk("coll_clr_low", coll_clr, 0);
  endtask

  task automatic move(input logic [3:0] b);
    frame(b, 4'b0000);
    frame(B_NONE, 4'b0000);
  endtask

  task automatic pos(input string tag, input int x, input int y);
    chk({tag, "_x"}, frog_x, x);
    chk({tag, "_y"}, frog_y, y);
  endtask

  initial begin
    rst_n = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    frame_start = 1'b0;
    collision   = 4'b0000;
    repeat (2) @(negedge dclk);
    pos("rst", 152, 240);
    chk("rst_state", state, 0);
    chk("rst_lives", lives, 3);
    chk("rst_level", level, 0);
    chk("rst_flash", flash, 0);
    chk("rst_coll_clr", coll_clr, 0);
    rst_n = 1'b1;
    @(negedge dclk);

    // First press only starts the game
    frame(B_R, 4'b0000);
    chk("start_state", state, 1);
    chk("start_x", frog_x, 152);
    frame(B_NONE, 4'b0000);
    move(B_R);
    chk("step_right", frog_x, 160);
    move(B_L);
    chk("step_left", frog_x, 152);

    for (int i = 0; i < 25; i++) move(B_U);
    pos("top_row", 152, 40);
    move(B_U);
    chk("up_dropped", frog_y, 40);
    move(B_L);
    chk("left_dropped", frog_x, 152);
    move(B_U | B_L);
    pos("up_left_prio", 152, 40);

    // Walk to the goal column
    for (int i = 0; i < 73; i++) move(B_R);
    chk("pre_goal_x", frog_x, 736);
    chk("pre_goal_state", state, 1);
    frame(B_R, 4'b0000);
    chk("goal_x", frog_x, 744);
    chk("win_state", state, 3);
    chk("win_flash", flash, 1);
    for (int i = 1; i <= 30; i++) begin
      frame(B_NONE, 4'b0000);
      if (i == 29) begin
        chk("win_hold_state", state, 3);
        chk("win_hold_x", frog_x, 744);
      end
    end
    chk("win_done_state", state, 1);
    chk("win_level", level, 1);
    chk("win_flash_off", flash, 0);
    pos("win_respawn", 152, 240);

    // First hit: frog frozen, presses and collisions ignored, blink every 8 frames
    move(B_U);
    chk("pre_hit_y", frog_y, 232);
    frame(B_NONE, 4'b0010);
    chk("hit1_state", state, 2);
    chk("hit1_flash", flash, 0);
    for (int i = 1; i <= 60; i++) begin
      frame((i == 5) ? B_R : B_NONE, (i == 10) ? 4'b0001 : 4'b0000);
      if (i == 7)  chk("hit_flash7", flash, 0);
      if (i == 8)  chk("hit_flash8", flash, 1);
      if (i == 16) chk("hit_flash16", flash, 0);
      if (i == 59) begin
        chk("hit_hold_state", state, 2);
        chk("hit_hold_lives", lives, 3);
        pos("hit_frozen", 152, 232);
      end
    end
    chk("hit1_done_state", state, 1);
    chk("hit1_lives", lives, 2);
    chk("hit1_flash_off", flash, 0);
    pos("hit1_respawn", 152, 240);

    frame(B_NONE, 4'b1000);
    chk("hit2_state", state, 2);
    for (int i = 0; i < 60; i++) frame(B_NONE, 4'b0000);
    chk("hit2_lives", lives, 1);
    chk("hit2_done_state", state, 1);
    frame(B_NONE, 4'b0100);
    for (int i = 0; i < 60; i++) frame(B_NONE, 4'b0000);
    chk("over_state", state, 4);
    chk("over_lives", lives, 0);
    chk("over_level", level, 1);

    frame(B_R, 4'b0000);
    chk("restart_state", state, 0);
    chk("restart_lives", lives, 3);
    chk("restart_level", level, 0);
    frame(B_NONE, 4'b0000);
    frame(B_R, 4'b0000);
    chk("replay_state", state, 1);
    chk("replay_x", frog_x, 152);
    frame(B_NONE, 4'b0000);

    // Collision beats a simultaneous arrival at the goal
    for (int i = 0; i < 73; i++) move(B_R);
    frame(B_R, 4'b0001);
    chk("coll_goal_state", state, 2);
    chk("coll_goal_x", frog_x, 736);
    chk("coll_goal_level", level, 0);
    for (int i = 1; i < 30; i++) frame(B_NONE, 4'b0000);
    chk("hit30_flash", flash, 1);
    chk("hit30_state", state, 2);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    pos("arst", 152, 240);
    chk("arst_lives", lives, 3);
    chk("arst_level", level, 0);
    chk("arst_flash", flash, 0);
    chk("arst_coll_clr", coll_clr, 0);
    @(negedge dclk);
    rst_n = 1'b1;
    repeat (2) @(negedge dclk);
    chk("post_rst_state", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
